// File: rtl/uart_fifo_bridge.sv
// Host-side bridge between a byte UART and two FIFOs.
// The TX FIFO feeds a three-state send sequencer; the RX FIFO collects UART bytes
// for the host and presents its head first-word-fall-through.
module uart_fifo_bridge #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tx_wr,
   input  logic [7:0]    tx_wdata,
   input  logic          rx_rd,
   output logic [7:0]    rx_rdata,
   input  logic          ovf_clr,
   output logic [AW:0]   tx_count,
   output logic [AW:0]   rx_count,
   output logic          tx_full,
   output logic          tx_empty,
   output logic          rx_full,
   output logic          rx_empty,
   output logic          tx_ovf,
   output logic          rx_ovf,
   output logic          irq,
   output logic [7:0]    uart_txdin,
   output logic          uart_txgo,
   input  logic          uart_txrdy,
   input  logic [7:0]    uart_rxdout,
   input  logic          uart_rxnew
);

   typedef enum logic [1:0] {IDLE, LOAD, BUSY} tx_state_e;

   tx_state_e         state_q, state_d;
   logic [7:0]        tx_mem_q [DEPTH];
   logic [7:0]        rx_mem_q [DEPTH];
   logic [AW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [AW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [AW:0]       tx_count_q, tx_count_d, rx_count_q, rx_count_d;
   logic              tx_full_q, tx_full_d, tx_empty_q, tx_empty_d;
   logic              rx_full_q, rx_full_d, rx_empty_q, rx_empty_d;
   logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic [7:0]        txdin_q, txdin_d;
   logic              tx_push, tx_pop, rx_push, rx_pop;

   // A full FIFO still accepts a push when the same cycle pops; an empty one ignores pops.
   always_comb begin
      tx_pop  = (state_q == IDLE) && !tx_empty_q && uart_txrdy;
      tx_push = tx_wr && (!tx_full_q || tx_pop);
      rx_pop  = rx_rd && !rx_empty_q;
      rx_push = uart_rxnew && (!rx_full_q || rx_pop);
   end

   // Pointer, occupancy, flag and overflow next-state for both FIFOs.
   always_comb begin
      tx_wptr_d  = tx_push ? tx_wptr_q + AW'(1) : tx_wptr_q;
      tx_rptr_d  = tx_pop  ? tx_rptr_q + AW'(1) : tx_rptr_q;
      rx_wptr_d  = rx_push ? rx_wptr_q + AW'(1) : rx_wptr_q;
      rx_rptr_d  = rx_pop  ? rx_rptr_q + AW'(1) : rx_rptr_q;
      tx_count_d = tx_count_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_count_d = rx_count_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      tx_full_d  = (tx_count_d == (AW+1)'(DEPTH));
      rx_full_d  = (rx_count_d == (AW+1)'(DEPTH));
      tx_empty_d = (tx_count_d == '0);
      rx_empty_d = (rx_count_d == '0);
      // a new overflow event wins over a coincident clear
      tx_ovf_d   = (tx_wr && !tx_push) || (tx_ovf_q && !ovf_clr);
      rx_ovf_d   = (uart_rxnew && !rx_push) || (rx_ovf_q && !ovf_clr);
   end

   // Send sequencer: pop into the output register, strobe once, wait for the UART.
   always_comb begin
      state_d = state_q;
      txdin_d = txdin_q;
      case (state_q)
         IDLE: if (tx_pop) begin
            txdin_d = tx_mem_q[tx_rptr_q];
            state_d = LOAD;
         end
         LOAD: state_d = BUSY;
         BUSY: if (uart_txrdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         txdin_q    <= '0;
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         tx_count_q <= '0;
         rx_count_q <= '0;
         tx_full_q  <= 1'b0;
         rx_full_q  <= 1'b0;
         tx_empty_q <= 1'b1;
         rx_empty_q <= 1'b1;
         tx_ovf_q   <= 1'b0;
         rx_ovf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         txdin_q    <= txdin_d;
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         tx_count_q <= tx_count_d;
         rx_count_q <= rx_count_d;
         tx_full_q  <= tx_full_d;
         rx_full_q  <= rx_full_d;
         tx_empty_q <= tx_empty_d;
         rx_empty_q <= rx_empty_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_ovf_q   <= rx_ovf_d;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= tx_wdata;
      if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rxdout;
   end

   assign tx_count   = tx_count_q;
   assign rx_count   = rx_count_q;
   assign tx_full    = tx_full_q;
   assign tx_empty   = tx_empty_q;
   assign rx_full    = rx_full_q;
   assign rx_empty   = rx_empty_q;
   assign tx_ovf     = tx_ovf_q;
   assign rx_ovf     = rx_ovf_q;
   assign uart_txdin = txdin_q;
   assign uart_txgo  = (state_q == LOAD);
   assign rx_rdata   = rx_empty_q ? 8'h00 : rx_mem_q[rx_rptr_q];
   assign irq        = !rx_empty_q || tx_ovf_q || rx_ovf_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: a vector table, hand-built corner sequences and a
// randomized run, all compared against a queue-based model of both FIFOs.
module tb_uart_fifo_bridge;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst, tx_wr, rx_rd, ovf_clr, uart_txrdy, uart_rxnew;
   logic [7:0]    tx_wdata, uart_rxdout, rx_rdata, uart_txdin;
   logic [AW:0]   tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf, irq, uart_txgo;

   always #5 clk = ~clk;

   uart_fifo_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd),
      .rx_rdata(rx_rdata), .ovf_clr(ovf_clr), .tx_count(tx_count), .rx_count(rx_count),
      .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
      .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .irq(irq), .uart_txdin(uart_txdin),
      .uart_txgo(uart_txgo), .uart_txrdy(uart_txrdy), .uart_rxdout(uart_rxdout),
      .uart_rxnew(uart_rxnew)
   );

   int nvec = 0;
   int nerr = 0;

   // reference model state
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic [7:0] sentq[$];
   bit         m_txovf, m_rxovf;
   bit         auto_uart;
   int         busy_cnt;
   logic       prev_go;

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       rd;
      logic       nw;
      logic [7:0] rxd;
      logic [4:0] e_txc;
      logic [4:0] e_rxc;
      logic [7:0] e_rdata;
      logic       e_irq;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: capture the applied inputs, advance, update the model, compare.
   task automatic tick();
      logic       s_rst, s_wr, s_rd, s_new, s_clr, s_rdy;
      logic [7:0] s_wd, s_rxd, e_rd;
      s_rst = rst; s_wr = tx_wr; s_rd = rx_rd; s_new = uart_rxnew; s_clr = ovf_clr;
      s_rdy = uart_txrdy; s_wd = tx_wdata; s_rxd = uart_rxdout;
      @(posedge clk);
      #1;
      if (s_rst) begin
         txq.delete(); rxq.delete();
         m_txovf = 0; m_rxovf = 0;
         check("txgo_rst", uart_txgo, 0);
         check("txdin_rst", uart_txdin, 0);
      end else begin
         if (s_clr) begin m_txovf = 0; m_rxovf = 0; end
         // a byte leaves the TX FIFO on the edge that raises uart_txgo
         if (uart_txgo) begin
            check("txgo_legal", (txq.size() > 0 && s_rdy && !prev_go), 1);
            if (txq.size() > 0) begin
               check("tx_byte", uart_txdin, txq[0]);
               sentq.push_back(uart_txdin);
               void'(txq.pop_front());
            end
         end
         if (s_wr) begin
            if (txq.size() < DEPTH) txq.push_back(s_wd);
            else m_txovf = 1;
         end
         if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
         if (s_new) begin
            if (rxq.size() < DEPTH) rxq.push_back(s_rxd);
            else m_rxovf = 1;
         end
      end
      e_rd = (rxq.size() > 0) ? rxq[0] : 8'h00;
      check("tx_count", tx_count, txq.size());
      check("tx_full", tx_full, txq.size() == DEPTH);
      check("tx_empty", tx_empty, txq.size() == 0);
      check("rx_count", rx_count, rxq.size());
      check("rx_full", rx_full, rxq.size() == DEPTH);
      check("rx_empty", rx_empty, rxq.size() == 0);
      check("rx_rdata", rx_rdata, e_rd);
      check("tx_ovf", tx_ovf, m_txovf);
      check("rx_ovf", rx_ovf, m_rxovf);
      check("irq", irq, (rxq.size() > 0) || m_txovf || m_rxovf);
      prev_go = uart_txgo;
      // simple UART: busy for a few cycles after each send strobe
      if (auto_uart) begin
         if (uart_txgo) busy_cnt = 3;
         else if (busy_cnt > 0) busy_cnt--;
         uart_txrdy = (busy_cnt == 0);
      end
   endtask

   task automatic clear_inputs();
      tx_wr = 0; tx_wdata = '0; rx_rd = 0; ovf_clr = 0; uart_rxnew = 0; uart_rxdout = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{0, 8'h00, 0, 1, 8'h3C, 5'd0, 5'd1, 8'h3C, 1'b1};
      tbl[1] = '{0, 8'h00, 0, 1, 8'hC3, 5'd0, 5'd2, 8'h3C, 1'b1};
      tbl[2] = '{0, 8'h00, 1, 0, 8'h00, 5'd0, 5'd1, 8'hC3, 1'b1};
      tbl[3] = '{0, 8'h00, 1, 0, 8'h00, 5'd0, 5'd0, 8'h00, 1'b0};
      tbl[4] = '{0, 8'h00, 1, 0, 8'h00, 5'd0, 5'd0, 8'h00, 1'b0};
      tbl[5] = '{0, 8'h00, 1, 1, 8'h5A, 5'd0, 5'd1, 8'h5A, 1'b1};
      tbl[6] = '{0, 8'h00, 0, 0, 8'h00, 5'd0, 5'd1, 8'h5A, 1'b1};
      tbl[7] = '{1, 8'h77, 1, 0, 8'h00, 5'd1, 5'd0, 8'h00, 1'b0};
      tbl[8] = '{1, 8'h88, 0, 0, 8'h00, 5'd2, 5'd0, 8'h00, 1'b0};

      auto_uart = 0; busy_cnt = 0; prev_go = 0; uart_txrdy = 0;
      do_reset();
      do_reset();

      // vector table with the transmitter held not-ready
      foreach (tbl[i]) begin
         tx_wr = tbl[i].wr; tx_wdata = tbl[i].wd; rx_rd = tbl[i].rd;
         uart_rxnew = tbl[i].nw; uart_rxdout = tbl[i].rxd;
         tick();
         check("tbl_txc", tx_count, tbl[i].e_txc);
         check("tbl_rxc", rx_count, tbl[i].e_rxc);
         check("tbl_rdata", rx_rdata, tbl[i].e_rdata);
         check("tbl_irq", irq, tbl[i].e_irq);
      end

      // single byte latency
      do_reset();
      auto_uart = 1; busy_cnt = 0; uart_txrdy = 1;
      tx_wr = 1; tx_wdata = 8'hA5;
      tick();
      tx_wr = 0;
      check("lat_go_early", uart_txgo, 0);
      tick();
      check("lat_go", uart_txgo, 1);
      check("lat_din", uart_txdin, 8'hA5);
      tick();
      check("go_one_cycle", uart_txgo, 0);
      check("tx_empty_after", tx_empty, 1);

      // fill TX, overflow, then drain in order
      do_reset();
      auto_uart = 0; uart_txrdy = 0; sentq.delete();
      for (int i = 1; i <= 16; i++) begin
         tx_wr = 1; tx_wdata = 8'(i);
         tick();
      end
      tx_wr = 0;
      check("txfill_full", tx_full, 1);
      check("txfill_count", tx_count, 16);
      check("txfill_ovf0", tx_ovf, 0);
      tx_wr = 1; tx_wdata = 8'h11;
      tick();
      tx_wr = 0;
      check("txfill_ovf1", tx_ovf, 1);
      auto_uart = 1; busy_cnt = 0; uart_txrdy = 1;
      for (int n = 0; n < 300 && sentq.size() < 16; n++) tick();
      check("tx_drain_n", sentq.size(), 16);
      for (int i = 0; i < 16 && i < sentq.size(); i++) check("tx_order", sentq[i], i + 1);
      check("tx_drained", tx_empty, 1);
      ovf_clr = 1;
      tick();
      ovf_clr = 0;
      check("txovf_clr", tx_ovf, 0);

      // RX full: simultaneous push/pop, then overflow, clear race and clear
      do_reset();
      auto_uart = 0; uart_txrdy = 0;
      for (int i = 0; i < 16; i++) begin
         uart_rxnew = 1; uart_rxdout = 8'(8'h20 + i);
         tick();
      end
      check("rxfill_full", rx_full, 1);
      uart_rxnew = 1; uart_rxdout = 8'hAA; rx_rd = 1;
      tick();
      check("rxboth_count", rx_count, 16);
      check("rxboth_ovf", rx_ovf, 0);
      check("rxboth_head", rx_rdata, 8'h21);
      rx_rd = 0; uart_rxdout = 8'hBB;
      tick();
      check("rxovf_set", rx_ovf, 1);
      ovf_clr = 1;
      tick();
      check("rxovf_race", rx_ovf, 1);
      uart_rxnew = 0;
      tick();
      ovf_clr = 0;
      check("rxovf_clr", rx_ovf, 0);

      // reset while the sequencer is busy with bytes queued
      do_reset();
      auto_uart = 1; busy_cnt = 0; uart_txrdy = 1;
      for (int i = 0; i < 4; i++) begin
         tx_wr = 1; tx_wdata = 8'(8'hD0 + i);
         tick();
      end
      tx_wr = 0;
      check("busy_queued", tx_count, 3);
      check("busy_rdy_low", uart_txrdy, 0);
      auto_uart = 0;
      do_reset();
      uart_txrdy = 1;
      check("rst_txc", tx_count, 0);
      check("rst_irq", irq, 0);
      for (int n = 0; n < 20; n++) begin
         tick();
         check("no_go_after_rst", uart_txgo, 0);
      end

      // randomized traffic with alternating pressure on the RX FIFO
      do_reset();
      auto_uart = 1; busy_cnt = 0; uart_txrdy = 1;
      for (int n = 0; n < 1500; n++) begin
         int pr;
         pr = ((n / 150) % 2 == 1) ? 75 : 30;
         tx_wr       = ($urandom_range(0, 99) < 35);
         tx_wdata    = 8'($urandom);
         uart_rxnew  = ($urandom_range(0, 99) < pr);
         uart_rxdout = 8'($urandom);
         rx_rd       = ($urandom_range(0, 99) < (100 - pr));
         ovf_clr     = ($urandom_range(0, 99) < 3);
         tick();
      end
      clear_inputs();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter DEPTH, default 16, entries per FIFO; power of two, 4..256.
REQ-002 Parameter AW, default 4, log2(DEPTH).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tx_wr  in  1  host write strobe to TX FIFO.
REQ-006 tx_wdata  in  8  host byte to transmit.
REQ-007 rx_rd  in  1  host pop strobe from RX FIFO.
REQ-008 rx_rdata  out  8  RX FIFO head byte, first-word-fall-through.
REQ-009 ovf_clr  in  1  clears both sticky overflow flags.
REQ-010 tx_count, rx_count  out  AW+1  current FIFO occupancy, 0..DEPTH.
REQ-011 tx_full, tx_empty, rx_full, rx_empty  out  1  FIFO status flags.
REQ-012 tx_ovf, rx_ovf  out  1  sticky overflow flags.
REQ-013 irq  out  1  interrupt level = ~rx_empty | tx_ovf | rx_ovf.
REQ-014 uart_txdin  out  8  byte to the UART transmitter.
REQ-015 uart_txgo  out  1  one-cycle send strobe to the UART.
REQ-016 uart_txrdy  in  1  UART transmitter ready, high when idle or in stop bit.
REQ-017 uart_rxdout  in  8  UART received byte.
REQ-018 uart_rxnew  in  1  UART new-byte strobe, one clock wide.

Function
REQ-019 The TX and RX FIFOs SHALL each be circular buffers of DEPTH bytes with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-020 A tx_wr while tx_full SHALL drop the byte, leave pointers unchanged, and set tx_ovf on the next edge.
REQ-021 A uart_rxnew while rx_full SHALL drop uart_rxdout, leave pointers unchanged, and set rx_ovf on the next edge.
REQ-022 An rx_rd while rx_empty SHALL be ignored with no state change and no flag set.
REQ-023 A simultaneous push and pop on a full FIFO SHALL perform both, leaving count at DEPTH and setting no overflow flag.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL perform only the push.
REQ-025 rx_rdata SHALL equal the RX head entry whenever rx_empty is 0, and SHALL be 8'h00 when rx_empty is 1.
REQ-026 ovf_clr SHALL clear both overflow flags; if ovf_clr coincides with a new overflow event, the flag SHALL be set.
REQ-027 The TX sequencer SHALL be an FSM with states IDLE, LOAD, and BUSY.
REQ-028 In IDLE with ~tx_empty and uart_txrdy high, the FSM SHALL pop the head into the uart_txdin register and move to LOAD.
REQ-029 In LOAD, uart_txgo SHALL be 1 for exactly that one cycle, uart_txdin SHALL be stable, and the FSM SHALL go to BUSY next.
REQ-030 In BUSY, the FSM SHALL return to IDLE on the first cycle with uart_txrdy high.
REQ-031 BUSY is never exited on its first cycle, since uart_txrdy is low then.
REQ-032 uart_txgo SHALL be 0 in IDLE and BUSY.
REQ-033 Latency from tx_wr into an empty TX FIFO, with uart_txrdy high, to uart_txgo SHALL be 2 clocks.
REQ-034 Bytes SHALL be transmitted in write order, and received bytes SHALL be readable in arrival order, with no loss below DEPTH.
REQ-035 Counts and flags SHALL update on the same edge as the pointer change and be registered outputs.

Reset
REQ-036 When rst is sampled high, the block SHALL set both FIFOs empty, both pointers to 0, counts to 0, and tx_empty = rx_empty = 1.
REQ-037 When rst is sampled high, the block SHALL set full flags to 0, overflow flags to 0, uart_txgo to 0, uart_txdin to 8'h00, and the FSM to IDLE.
REQ-038 A reset asserted mid-transmission SHALL discard queued and in-flight TX data, and irq SHALL be 0 after reset.

Verification
REQ-039 Reset then tx_wr 8'hA5 with uart_txrdy=1 -> uart_txgo=1 for one clock, 2 clocks later, with uart_txdin=8'hA5; tx_empty=1 afterwards.
REQ-040 Write 8'h01..8'h10 with uart_txrdy=0 -> tx_full=1, tx_count=16; a 17th write sets tx_ovf; releasing uart_txrdy transmits 8'h01..8'h10 in order.
REQ-041 Pulse uart_rxnew with 8'h3C then 8'hC3 -> irq=1, rx_count=2, rx_rdata=8'h3C; after rx_rd, rx_rdata=8'hC3.
REQ-042 Fill RX to 16, then uart_rxnew and rx_rd in the same cycle -> rx_count stays 16 and rx_ovf stays 0; uart_rxnew alone sets rx_ovf; ovf_clr clears it.
REQ-043 Assert rst while in BUSY with 3 bytes queued -> FSM IDLE, tx_count=0, uart_txgo never asserted after reset.
REQ-044 Run 40 pushes and pops through the RX FIFO to exercise pointer wrap -> data order is preserved.
